// File: rtl/axi_read_arbiter_pkg.sv
// axi_arb_pkg: shared FSM state type and ID-width sanity helper for axi_read_arbiter.
// Contents: arb_state_e (IDLE/ADDR/DATA), id_width_ok() used at elaboration by the top.
package axi_arb_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;

    // The slave ID must carry the master ID plus enough upper bits to tag the winning master.
    function automatic bit id_width_ok(int nb_master, int id_master_w, int id_slave_w);
        return id_slave_w == id_master_w + $clog2(nb_master);
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: AR/R signal bundle between NB_MASTER masters, the arbiter and one slave.
// Ports (signals): m_ar_* / m_r_* master side (per-master valid/ready, shared R payload),
// s_ar_* / s_r_* slave side. Modport slave is the arbiter's view, modport master the environment's.
interface axi_read_arbiter_if #(
    parameter int NB_MASTER           = 3,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH      = 32,
    parameter int AXI_ID_MASTER_WIDTH = 2,
    parameter int AXI_ID_SLAVE_WIDTH  = 4
);
    logic [NB_MASTER-1:0]           m_ar_valid;
    logic [NB_MASTER-1:0]           m_ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]      m_ar_addr [NB_MASTER];
    logic [AXI_ID_MASTER_WIDTH-1:0] m_ar_id   [NB_MASTER];
    logic [7:0]                     m_ar_len  [NB_MASTER];
    logic [NB_MASTER-1:0]           m_r_valid;
    logic [NB_MASTER-1:0]           m_r_ready;
    logic [AXI_DATA_WIDTH-1:0]      m_r_data;
    logic [1:0]                     m_r_resp;
    logic                           m_r_last;
    logic [AXI_ID_MASTER_WIDTH-1:0] m_r_id;
    logic                           s_ar_valid;
    logic                           s_ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]      s_ar_addr;
    logic [AXI_ID_SLAVE_WIDTH-1:0]  s_ar_id;
    logic [7:0]                     s_ar_len;
    logic                           s_r_valid;
    logic                           s_r_ready;
    logic [AXI_DATA_WIDTH-1:0]      s_r_data;
    logic [1:0]                     s_r_resp;
    logic                           s_r_last;
    logic [AXI_ID_SLAVE_WIDTH-1:0]  s_r_id;

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, m_r_ready,
               s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id,
        output m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last, m_r_id,
               s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_r_ready
    );

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, m_r_ready,
               s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last, m_r_id,
               s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_r_ready
    );
endinterface

// File: rtl/axi_read_arbiter_rr_arb_sel.sv
// rr_arb_sel: round-robin pick of the first request at or after a pointer, wrapping.
// Ports: i_req (request vector), i_ptr (start index), o_grant (one-hot winner), o_idx (winner index).
module rr_arb_sel #(
    parameter  int NB_MASTER = 3,
    localparam int IW        = $clog2(NB_MASTER)
) (
    input  logic [NB_MASTER-1:0] i_req,
    input  logic [IW-1:0]        i_ptr,
    output logic [NB_MASTER-1:0] o_grant,
    output logic [IW-1:0]        o_idx
);
    logic [NB_MASTER-1:0] w_rot;

    // Rotate so bit k is the request k places after the pointer.
    assign w_rot = NB_MASTER'({i_req, i_req} >> i_ptr);

    // Scan downward so the smallest offset is the final assignment.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = NB_MASTER - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx   = IW'((int'(i_ptr) + k) % NB_MASTER);
                o_grant = NB_MASTER'(1) << o_idx;
            end
        end
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read slave among NB_MASTER masters, one burst outstanding.
// Ports: clk, rst (sync active-high); bus (axi_read_arbiter_if.slave) carrying master AR/R
// and slave AR/R channels. Slave ID = {winner index, master ID}.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NB_MASTER           = 3,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int AXI_DATA_WIDTH      = 32,
    parameter int AXI_ID_MASTER_WIDTH = 2,
    parameter int AXI_ID_SLAVE_WIDTH  = 4
) (
    input logic               clk,
    input logic               rst,
    axi_read_arbiter_if.slave bus
);
    localparam int IW = $clog2(NB_MASTER);

    if (!id_width_ok(NB_MASTER, AXI_ID_MASTER_WIDTH, AXI_ID_SLAVE_WIDTH)) begin : g_bad_id
        $error("AXI_ID_SLAVE_WIDTH must equal AXI_ID_MASTER_WIDTH + clog2(NB_MASTER)");
    end

    arb_state_e                     r_state;
    arb_state_e                     w_state_nxt;
    logic [IW-1:0]                  r_ptr;
    logic [IW-1:0]                  r_g;
    logic [AXI_ADDR_WIDTH-1:0]      r_addr;
    logic [AXI_ID_MASTER_WIDTH-1:0] r_id;
    logic [7:0]                     r_len;
    logic [7:0]                     r_beat_cnt;
    logic [NB_MASTER-1:0]           w_grant;
    logic [IW-1:0]                  w_idx;
    logic                           w_idle;
    logic                           w_addr_ph;
    logic                           w_data_ph;
    logic                           w_r_hs;

    rr_arb_sel #(.NB_MASTER(NB_MASTER)) u_sel (
        .i_req   (bus.m_ar_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Phases are gated by rst so every handshake output is low while reset is held.
    assign w_idle    = !rst && r_state == IDLE;
    assign w_addr_ph = !rst && r_state == ADDR;
    assign w_data_ph = !rst && r_state == DATA;
    assign w_r_hs    = w_data_ph && bus.s_r_valid && bus.m_r_ready[r_g];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_g        <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && |bus.m_ar_valid) begin
                r_g        <= w_idx;
                r_addr     <= bus.m_ar_addr[w_idx];
                r_id       <= bus.m_ar_id[w_idx];
                r_len      <= bus.m_ar_len[w_idx];
                r_beat_cnt <= '0;
            end
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (bus.s_r_last)
                    r_ptr <= (r_g == IW'(NB_MASTER - 1)) ? '0 : r_g + IW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = |bus.m_ar_valid ? ADDR : IDLE;
            ADDR:    w_state_nxt = bus.s_ar_ready ? DATA : ADDR;
            DATA:    w_state_nxt = (w_r_hs && bus.s_r_last) ? IDLE : DATA;
            default: w_state_nxt = IDLE;
        endcase
        bus.m_ar_ready = w_idle ? w_grant : '0;
        bus.s_ar_valid = w_addr_ph;
        bus.s_ar_addr  = r_addr;
        bus.s_ar_id    = {r_g, r_id};
        bus.s_ar_len   = r_len;
        bus.m_r_valid  = w_data_ph ? (NB_MASTER'(bus.s_r_valid) << r_g) : '0;
        bus.s_r_ready  = w_data_ph && bus.m_r_ready[r_g];
        bus.m_r_data   = bus.s_r_data;
        bus.m_r_resp   = bus.s_r_resp;
        bus.m_r_last   = bus.s_r_last;
        bus.m_r_id     = bus.s_r_id[AXI_ID_MASTER_WIDTH-1:0];
    end

    // Flags slaves whose burst length or returned winner tag disagrees with the request.
    cover property (@(posedge clk) w_r_hs && bus.s_r_last &&
        (r_beat_cnt != r_len || bus.s_r_id[AXI_ID_SLAVE_WIDTH-1:AXI_ID_MASTER_WIDTH] != r_g));
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed and randomized checks of axi_read_arbiter against a transaction-level model.
module tb_axi_read_arbiter;
    import axi_arb_pkg::*;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDM = 2;
    localparam int IDS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_read_arbiter_if #(
        .NB_MASTER(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_MASTER_WIDTH(IDM), .AXI_ID_SLAVE_WIDTH(IDS)
    ) bus ();

    axi_read_arbiter #(
        .NB_MASTER(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_MASTER_WIDTH(IDM), .AXI_ID_SLAVE_WIDTH(IDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Master request holders
    logic           rq_v    [N];
    logic [AW-1:0]  rq_addr [N];
    logic [IDM-1:0] rq_id   [N];
    logic [7:0]     rq_len  [N];

    // Stimulus knobs (percent probabilities)
    int p_new = 0, p_arrdy = 100, p_rv = 100, p_mrdy = 100, force_resp = -1;
    bit stray = 0;

    // Reference model: one burst in flight, round-robin pointer, slave burst queue
    bit             busy = 0, ar_done = 0;
    int             ptr = 0, g = 0;
    logic [AW-1:0]  e_addr;
    logic [IDM-1:0] e_id;
    logic [7:0]     e_len;
    int             sl_left = 0;
    logic [IDS-1:0] sl_id;
    int             beats [N];
    int             grants [$];
    int             cyc = 0, grant_cyc = 0, sav_cyc = -1;
    logic [IDS-1:0] first_sid;
    logic           obs_sav, obs_srdy, last_last;
    logic [AW-1:0]  obs_saddr;
    logic [IDS-1:0] obs_sid;
    logic [N-1:0]   obs_mrv;
    logic [1:0]     last_resp;

    function automatic int rr_pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic new_req(int i);
        rq_v[i]    = 1'b1;
        rq_addr[i] = $urandom;
        rq_id[i]   = IDM'($urandom);
        rq_len[i]  = 8'($urandom_range(0, 3));
    endtask

    task automatic set_req(int i, logic [AW-1:0] a, logic [IDM-1:0] id, logic [7:0] len);
        rq_v[i] = 1'b1; rq_addr[i] = a; rq_id[i] = id; rq_len[i] = len;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!rq_v[i] && $urandom_range(99) < p_new) new_req(i);
            bus.m_ar_valid[i] = rq_v[i];
            bus.m_ar_addr[i]  = rq_addr[i];
            bus.m_ar_id[i]    = rq_id[i];
            bus.m_ar_len[i]   = rq_len[i];
            bus.m_r_ready[i]  = $urandom_range(99) < p_mrdy;
        end
        bus.s_ar_ready = $urandom_range(99) < p_arrdy;
        bus.s_r_valid  = sl_left > 0 ? $urandom_range(99) < p_rv : stray && $urandom_range(99) < 30;
        bus.s_r_last   = sl_left == 1;
        bus.s_r_data   = $urandom;
        bus.s_r_resp   = force_resp >= 0 ? 2'(force_resp) : 2'($urandom);
        bus.s_r_id     = sl_left > 0 ? sl_id : IDS'($urandom);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model on the handshakes due at the next edge.
    task automatic cycle();
        logic [N-1:0] v, exp_rdy, exp_mrv;
        logic         exp_srdy;
        int           w;
        drive();
        for (int i = 0; i < N; i++) v[i] = rq_v[i];
        @(negedge clk);
        w       = busy ? -1 : rr_pick(v, ptr);
        exp_rdy = w < 0 ? '0 : N'(1) << w;
        check("m_ar_ready", bus.m_ar_ready, exp_rdy);
        check("s_ar_valid", bus.s_ar_valid, busy && !ar_done);
        if (busy && !ar_done) begin
            check("s_ar_addr", bus.s_ar_addr, e_addr);
            check("s_ar_id", bus.s_ar_id, g * (1 << IDM) + e_id);
            check("s_ar_len", bus.s_ar_len, e_len);
            if (sav_cyc < 0) begin sav_cyc = cyc; first_sid = bus.s_ar_id; end
        end
        exp_srdy = busy && ar_done && bus.m_r_ready[g];
        exp_mrv  = (busy && ar_done && bus.s_r_valid) ? N'(1) << g : '0;
        check("s_r_ready", bus.s_r_ready, exp_srdy);
        check("m_r_valid", bus.m_r_valid, exp_mrv);
        if (exp_mrv != '0) begin
            check("m_r_data", bus.m_r_data, bus.s_r_data);
            check("m_r_resp", bus.m_r_resp, bus.s_r_resp);
            check("m_r_last", bus.m_r_last, bus.s_r_last);
            check("m_r_id", bus.m_r_id, 64'(bus.s_r_id) % (1 << IDM));
        end
        obs_sav = bus.s_ar_valid; obs_saddr = bus.s_ar_addr; obs_sid = bus.s_ar_id;
        obs_srdy = bus.s_r_ready; obs_mrv = bus.m_r_valid;
        if (w >= 0) begin
            busy = 1; ar_done = 0; g = w;
            e_addr = rq_addr[w]; e_id = rq_id[w]; e_len = rq_len[w];
            grants.push_back(w); grant_cyc = cyc; rq_v[w] = 1'b0;
        end else if (busy && !ar_done && bus.s_ar_ready) begin
            ar_done = 1; sl_left = e_len + 1; sl_id = IDS'(g * (1 << IDM) + e_id);
        end else if (busy && ar_done && bus.s_r_valid && exp_srdy) begin
            beats[g]++; sl_left--;
            last_resp = bus.m_r_resp; last_last = bus.m_r_last;
            if (sl_left == 0) begin busy = 0; ptr = (g + 1) % N; end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("rst m_ar_ready", bus.m_ar_ready, 0);
            check("rst m_r_valid", bus.m_r_valid, 0);
            check("rst s_ar_valid", bus.s_ar_valid, 0);
            check("rst s_r_ready", bus.s_r_ready, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        busy = 0; ar_done = 0; ptr = 0; sl_left = 0;
    endtask

    // Run until a new grant has happened and its burst completed.
    task automatic run_burst(string tag);
        int n0 = grants.size();
        for (int k = 0; k < 200 && (grants.size() == n0 || busy); k++) cycle();
        check(tag, busy == 0 && grants.size() > n0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && busy; k++) cycle();
        check("drain", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, n0;
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 0; rq_addr[i] = '0; rq_id[i] = '0; rq_len[i] = '0; beats[i] = 0;
        end
        drive();
        do_reset(3);
        check("reset state", 64'(dut.r_state), 64'(IDLE));
        check("reset ptr", 64'(dut.r_ptr), 0);

        // Single request from master 1, 4-beat burst
        set_req(1, 32'h0010_0000, 2'b01, 8'd3);
        grants.delete(); sav_cyc = -1;
        run_burst("s1 burst");
        check("s1 grant", grants.size() == 1 ? grants[0] : -1, 1);
        check("s1 ar lag", sav_cyc - grant_cyc, 1);
        check("s1 ar id", first_sid, 4'b0101);
        check("s1 beats m1", beats[1], 4);
        check("s1 beats others", beats[0] + beats[2], 0);
        check("s1 idle", 64'(dut.r_state), 64'(IDLE));

        // All masters requesting continuously after reset
        do_reset(2);
        p_new = 100;
        grants.delete();
        for (int k = 0; k < 300 && grants.size() < 6; k++) cycle();
        p_new = 0;
        for (int i = 0; i < N; i++) rq_v[i] = 0;
        drain();
        for (int k = 0; k < 6; k++)
            check("rr order", k < grants.size() ? grants[k] : -1, k % 3);

        // Slave AR stall for 5 cycles with stray R beats
        p_arrdy = 0; stray = 1;
        set_req(2, 32'hABCD_0040, 2'b10, 8'd1);
        b0 = beats[0] + beats[1] + beats[2];
        n0 = grants.size();
        for (int k = 0; k < 20 && grants.size() == n0; k++) cycle();
        repeat (5) begin
            cycle();
            check("hold s_ar_valid", obs_sav, 1);
            check("hold s_ar_addr", obs_saddr, 32'hABCD_0040);
            check("hold s_ar_id", obs_sid, 4'b1010);
            check("hold no r", obs_mrv, 0);
        end
        check("hold beats", beats[0] + beats[1] + beats[2], b0);
        p_arrdy = 100; stray = 0;
        drain();

        // Master R backpressure for 3 cycles
        set_req(0, 32'h0000_2000, 2'b11, 8'd3);
        b0 = beats[0];
        for (int k = 0; k < 40 && beats[0] == b0; k++) cycle();
        check("bp first beat", beats[0] - b0, 1);
        p_mrdy = 0;
        repeat (3) begin
            cycle();
            check("bp s_r_ready", obs_srdy, 0);
            check("bp m_r_valid", obs_mrv, 3'b001);
        end
        p_mrdy = 100;
        drain();
        check("bp beats", beats[0] - b0, 4);

        // Single-beat DECERR burst
        force_resp = 3;
        set_req(1, 32'h0000_0300, 2'b00, 8'd0);
        b0 = beats[1];
        run_burst("decerr burst");
        check("decerr beats", beats[1] - b0, 1);
        check("decerr resp", last_resp, 2'b11);
        check("decerr last", last_last, 1);
        force_resp = -1;

        // Reset during beat 2 of a 4-beat burst
        set_req(2, 32'h0000_4000, 2'b01, 8'd3);
        b0 = beats[2];
        for (int k = 0; k < 40 && beats[2] == b0; k++) cycle();
        check("mid first beat", beats[2] - b0, 1);
        check("mid ptr before", 64'(dut.r_ptr), 2);
        drive();
        do_reset(1);
        check("mid state", 64'(dut.r_state), 64'(IDLE));
        check("mid ptr", 64'(dut.r_ptr), 0);
        for (int i = 0; i < N; i++) rq_v[i] = 0;
        cycle();

        // Randomized traffic
        p_new = 40; p_arrdy = 70; p_rv = 70; p_mrdy = 70; stray = 1;
        n0 = grants.size();
        repeat (3000) cycle();
        p_new = 0; stray = 0;
        for (int i = 0; i < N; i++) rq_v[i] = 0;
        drain();
        check("rand progress", grants.size() - n0 > 50, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
